// File: rtl/fc_in_reader_if.sv
// Bundle for fc_in_reader: start/pass-count control, flatten-buffer read port,
// chunk stream toward the FC1 MAC array, and status.
interface fc_in_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PASS_W     = 8
);
  logic                     start;
  logic [PASS_W-1:0]        num_passes;
  logic [4:0]               fcin_addr;
  logic                     fc1_en;
  logic [DATA_WIDTH*32-1:0] fcin_data;
  logic [DATA_WIDTH*8-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     out_final;
  logic                     busy;
  logic                     done;

  // master: the reader itself
  modport master (
    input  start, num_passes, fcin_data, out_ready,
    output fcin_addr, fc1_en, out_data, out_valid, out_last, out_final, busy, done
  );

  // slave: controller + buffer + MAC array around the reader
  modport slave (
    output start, num_passes, fcin_data, out_ready,
    input  fcin_addr, fc1_en, out_data, out_valid, out_last, out_final, busy, done
  );
endinterface

// File: rtl/fc_in_reader.sv
// FC1 input streamer: reads the 32-word flattened vector from a 1-cycle BRAM,
// slices each word into four 8-element chunks and streams them under
// valid/ready, replaying the whole vector num_passes times.
module fc_in_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PASS_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fc_in_reader_if.master  bus
);
  localparam int NUM_LANES  = 8;
  localparam int NUM_CHUNKS = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // word viewed as chunks of lanes so the slice is a plain index
  typedef logic [NUM_CHUNKS-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] word_t;

  state_t            r_state, w_state_nxt;
  logic [PASS_W-1:0] r_np;
  logic [PASS_W-1:0] w_np_m1;

  // read side
  logic [4:0]        r_rd_word;
  logic [PASS_W-1:0] r_rd_pass;
  logic              r_rd_active;
  logic              r_rd_pend;     // data for last cycle's read is on fcin_data now

  // two-slot word buffer
  word_t             r_cur, r_nxt;
  logic              r_cur_vld, r_nxt_vld;

  // consume side
  logic [1:0]        r_chunk;
  logic [4:0]        r_word;
  logic [PASS_W-1:0] r_pass;

  logic              w_start_ok, w_valid, w_hs, w_pop, w_last, w_final, w_issue;
  logic [1:0]        w_committed;

  assign w_np_m1    = r_np - PASS_W'(1);
  assign w_start_ok = (r_state == S_IDLE) && bus.start && (bus.num_passes != '0);
  assign w_valid    = (r_state == S_RUN) && r_cur_vld;
  assign w_hs       = w_valid && bus.out_ready;
  assign w_pop      = w_hs && (r_chunk == 2'd3);
  assign w_last     = w_valid && (r_word == 5'd31) && (r_chunk == 2'd3);
  assign w_final    = w_last && (r_pass == w_np_m1);

  // Words held or in flight. A read issued now lands next cycle; it is only
  // allowed if, after this cycle's pop, fewer than two slots are spoken for.
  assign w_committed = {1'b0, r_cur_vld} + {1'b0, r_nxt_vld} + {1'b0, r_rd_pend};
  assign w_issue     = (r_state == S_RUN) && r_rd_active &&
                       ((w_committed - {1'b0, w_pop}) < 2'd2);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state: RUN until the final chunk handshakes, one DRAIN cycle for done
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_hs && w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs: all decoded from registers (out_ready only gates the read issue)
  always_comb begin
    bus.fc1_en    = w_issue;
    bus.fcin_addr = r_rd_word;
    bus.out_valid = w_valid;
    bus.out_data  = w_valid ? r_cur[r_chunk] : '0;
    bus.out_last  = w_last;
    bus.out_final = w_final;
    bus.busy      = (r_state == S_RUN);
    bus.done      = (r_state == S_DRAIN);
  end

  // pass count latch and consume position (chunk -> word -> pass)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_np    <= '0;
      r_chunk <= '0;
      r_word  <= '0;
      r_pass  <= '0;
    end else if (w_start_ok) begin
      r_np    <= bus.num_passes;
      r_chunk <= '0;
      r_word  <= '0;
      r_pass  <= '0;
    end else if (w_hs) begin
      r_chunk <= r_chunk + 2'd1;
      if (r_chunk == 2'd3) begin
        r_word <= r_word + 5'd1;
        if (r_word == 5'd31) r_pass <= r_pass + PASS_W'(1);
      end
    end
  end

  // read sequencer: words 0..31 per pass, stops after the last pass's word 31
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_word   <= '0;
      r_rd_pass   <= '0;
      r_rd_active <= 1'b0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_start_ok) begin
        r_rd_word   <= '0;
        r_rd_pass   <= '0;
        r_rd_active <= 1'b1;
      end else if (w_issue) begin
        r_rd_word <= r_rd_word + 5'd1;
        if (r_rd_word == 5'd31) begin
          if (r_rd_pass == w_np_m1) r_rd_active <= 1'b0;
          else                      r_rd_pass   <= r_rd_pass + PASS_W'(1);
        end
      end
    end
  end

  // buffer fill/shift: returning data goes to cur if it is (or becomes) free,
  // otherwise to nxt; a pop promotes nxt into cur
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur     <= '0;
      r_nxt     <= '0;
      r_cur_vld <= 1'b0;
      r_nxt_vld <= 1'b0;
    end else if (w_start_ok) begin
      r_cur_vld <= 1'b0;
      r_nxt_vld <= 1'b0;
    end else if (w_pop) begin
      if (r_nxt_vld) begin
        r_cur     <= r_nxt;
        r_cur_vld <= 1'b1;
        r_nxt_vld <= r_rd_pend;
        if (r_rd_pend) r_nxt <= bus.fcin_data;
      end else begin
        r_cur_vld <= r_rd_pend;
        if (r_rd_pend) r_cur <= bus.fcin_data;
      end
    end else if (r_rd_pend) begin
      if (!r_cur_vld) begin
        r_cur     <= bus.fcin_data;
        r_cur_vld <= 1'b1;
      end else begin
        r_nxt     <= bus.fcin_data;
        r_nxt_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fc_in_reader.sv
// Directed bench for fc_in_reader: BRAM model with word w lane j = w*32+j,
// so chunk n (within a pass) must carry elements 8n..8n+7.
module tb_fc_in_reader;
  localparam int DW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fc_in_reader_if #(.DATA_WIDTH(DW), .PASS_W(PW)) bus();
  fc_in_reader #(.DATA_WIDTH(DW), .PASS_W(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [DW*32-1:0] mk_word(input logic [4:0] w);
    logic [DW*32-1:0] v;
    for (int j = 0; j < 32; j++) v[j*DW +: DW] = DW'(int'(w) * 32 + j);
    return v;
  endfunction

  // 1-cycle-latency buffer read port
  always @(posedge clk) if (bus.fc1_en) bus.fcin_data <= mk_word(bus.fcin_addr);

  int n_cmp = 0, n_err = 0;
  int cyc, n_rd, n_busy, n_done, done_cyc, first_rd, first_vld, n_hs, tot;
  int bad_data, bad_last, bad_final, n_last, n_final, hs_final_cyc;
  int n_bubble, n_unstable, pops, max_out;
  bit prev_stall;
  logic [DW*8-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear(input int total);
    cyc = 0; n_rd = 0; n_busy = 0; n_done = 0; done_cyc = -1; first_rd = -1;
    first_vld = -1; n_hs = 0; tot = total; bad_data = 0; bad_last = 0;
    bad_final = 0; n_last = 0; n_final = 0; hs_final_cyc = -1; n_bubble = 0;
    n_unstable = 0; pops = 0; max_out = 0; prev_stall = 0; prev_data = '0;
  endtask

  // one clock: called at posedge+1 with inputs set; samples at posedge+3
  task automatic tick();
    #2;
    if (bus.fc1_en) begin n_rd++; if (first_rd < 0) first_rd = cyc; end
    if (bus.busy) n_busy++;
    if (bus.out_valid && first_vld < 0) first_vld = cyc;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) n_unstable++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (first_vld >= 0 && hs_final_cyc < 0 && bus.out_ready && !bus.out_valid) n_bubble++;
    if (bus.out_valid && bus.out_ready) begin
      bit bad = 0;
      for (int k = 0; k < 8; k++)
        if (bus.out_data[k*DW +: DW] !== DW'((n_hs % 128) * 8 + k)) bad = 1;
      if (bad) bad_data++;
      if (bus.out_last !== ((n_hs % 128) == 127)) bad_last++;
      if (bus.out_last === 1'b1) n_last++;
      if (bus.out_final !== (n_hs == tot - 1)) bad_final++;
      if (bus.out_final === 1'b1) n_final++;
      if (n_hs == tot - 1) hs_final_cyc = cyc;
      n_hs++;
      if (n_hs % 4 == 0) pops++;
    end
    if (n_rd - pops > max_out) max_out = n_rd - pops;
    if (bus.done) begin n_done++; done_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
  endtask

  // full transaction; exp_done < 0 means only relative done timing is checked
  task automatic run(input string tag, input int np, input bit rnd, input int stall_hs,
                     input int stall_len, input int inj_cyc, input int exp_done);
    int stalled = 0;
    clear(128 * np);
    bus.start = 1'b1; bus.num_passes = PW'(np); bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    while (n_done == 0 && cyc < 4000) begin
      if (stall_len > 0 && n_hs == stall_hs && stalled < stall_len) begin
        bus.out_ready = 1'b0; stalled++;
      end else begin
        bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (cyc == inj_cyc) begin bus.start = 1'b1; bus.num_passes = PW'(5); end
      else bus.start = 1'b0;
      tick();
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
    check({tag, "_valid_after"}, 64'(bus.out_valid), 64'(0));
    tick();
    check({tag, "_first_rd"}, 64'(first_rd), 64'(1));
    check({tag, "_first_vld"}, 64'(first_vld), 64'(3));
    check({tag, "_hs"}, 64'(n_hs), 64'(128 * np));
    check({tag, "_reads"}, 64'(n_rd), 64'(32 * np));
    check({tag, "_bad_data"}, 64'(bad_data), 64'(0));
    check({tag, "_bad_last"}, 64'(bad_last), 64'(0));
    check({tag, "_n_last"}, 64'(n_last), 64'(np));
    check({tag, "_bad_final"}, 64'(bad_final), 64'(0));
    check({tag, "_n_final"}, 64'(n_final), 64'(1));
    check({tag, "_done_pulses"}, 64'(n_done), 64'(1));
    check({tag, "_done_rel"}, 64'(done_cyc), 64'(hs_final_cyc + 1));
    check({tag, "_outstanding_le2"}, 64'(max_out <= 2), 64'(1));
    check({tag, "_unstable"}, 64'(n_unstable), 64'(0));
    if (exp_done >= 0) check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    if (!rnd) check({tag, "_bubbles"}, 64'(n_bubble), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.num_passes = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_fc1_en", 64'(bus.fc1_en), 64'(0));
    check("rst_addr", 64'(bus.fcin_addr), 64'(0));
    check("rst_data", 64'(|bus.out_data), 64'(0));
    check("rst_last", 64'(bus.out_last), 64'(0));
    check("rst_final", 64'(bus.out_final), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single pass: 3 + 128 chunks, done at cycle 131
    run("p1", 1, 1'b0, -1, 0, -1, 131);
    // three passes back to back, no bubbles: done at 3 + 384
    run("p3", 3, 1'b0, -1, 0, -1, 387);
    // random backpressure, two passes
    run("rnd2", 2, 1'b1, -1, 0, -1, -1);

    // num_passes = 0 is ignored
    clear(0);
    bus.start = 1'b1; bus.num_passes = '0; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check("np0_reads", 64'(n_rd), 64'(0));
    check("np0_busy", 64'(n_busy), 64'(0));
    check("np0_done", 64'(n_done), 64'(0));

    // start pulse during RUN (cycle 20) changes nothing
    run("inj", 1, 1'b0, -1, 0, 20, 131);

    // reset while chunk 50 is presented (cycle 53)
    clear(128);
    bus.start = 1'b1; bus.num_passes = PW'(1); bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (52) tick();
    check("mid_chunk50_valid", 64'(bus.out_valid), 64'(1));
    check("mid_chunk50_lane0", 64'(bus.out_data[DW-1:0]), 64'(400));
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_data", 64'(|bus.out_data), 64'(0));
    check("mid_rst_fc1_en", 64'(bus.fc1_en), 64'(0));
    check("mid_rst_addr", 64'(bus.fcin_addr), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_last", 64'(bus.out_last), 64'(0));
    rst_n = 1'b1;
    tick();
    run("rst_re", 1, 1'b0, -1, 0, -1, 131);

    // 20-cycle stall on word 31 chunk 3 of pass 0: done at 3 + 256 + 20
    run("stall", 2, 1'b0, 127, 20, -1, 279);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
